// File: rtl/vstu_bresp_tracker.sv
// rtl/vstu_bresp_tracker.sv - per-instruction B-response commit tracker with AW credit
// Retires each vector store once all of its declared AXI bursts have been B-acked.
module vstu_bresp_tracker #(
    parameter int QueueDepth     = 4,
    parameter int IdWidth        = 3,
    parameter int BurstCntWidth  = 16,
    parameter int MaxOutstanding = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     insn_valid_i,
    output logic                     insn_ready_o,
    input  logic [IdWidth-1:0]       insn_id_i,
    input  logic [BurstCntWidth-1:0] insn_nbursts_i,
    input  logic                     aw_fire_i,
    output logic                     aw_credit_o,
    input  logic                     b_valid_i,
    input  logic [1:0]               b_resp_i,
    output logic                     b_ready_o,
    output logic                     done_valid_o,
    output logic [IdWidth-1:0]       done_id_o,
    output logic                     done_err_o,
    output logic                     store_pending_o,
    output logic                     proto_err_o
);

    localparam int PtrW = $clog2(QueueDepth);
    localparam int CntW = PtrW + 1;
    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(QueueDepth);
    localparam logic [OutW-1:0] OutMax  = OutW'(MaxOutstanding);

    logic [IdWidth-1:0]       id_q  [QueueDepth];
    logic [IdWidth-1:0]       id_d  [QueueDepth];
    logic [BurstCntWidth-1:0] rem_q [QueueDepth];
    logic [BurstCntWidth-1:0] rem_d [QueueDepth];
    logic                     err_q [QueueDepth];
    logic                     err_d [QueueDepth];

    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [OutW-1:0]    outstanding_q, outstanding_d;
    logic               proto_err_q, proto_err_d;
    logic               done_valid_q, done_valid_d;
    logic [IdWidth-1:0] done_id_q, done_id_d;
    logic               done_err_q, done_err_d;

    logic                     empty;
    logic [BurstCntWidth-1:0] head_rem;
    logic                     accept;
    logic                     b_fire;
    logic                     retire;
    logic                     resp_err;

    assign empty           = (count_q == '0);
    assign head_rem        = rem_q[rd_ptr_q];
    assign insn_ready_o    = (count_q != CntFull);
    assign b_ready_o       = !empty && (head_rem != '0);
    assign aw_credit_o     = (outstanding_q < OutMax);
    assign store_pending_o = !empty;
    assign proto_err_o     = proto_err_q;
    assign done_valid_o    = done_valid_q;
    assign done_id_o       = done_id_q;
    assign done_err_o      = done_err_q;

    assign accept   = insn_valid_i && insn_ready_o;
    assign b_fire   = b_valid_i && b_ready_o;
    // SLVERR and DECERR are the only failing responses; OKAY/EXOKAY both succeed.
    assign resp_err = (b_resp_i == 2'b10) || (b_resp_i == 2'b11);
    assign retire   = !empty && ((head_rem == '0) ||
                                 (b_fire && (head_rem == BurstCntWidth'(1))));

    always_comb begin
        id_d          = id_q;
        rem_d         = rem_q;
        err_d         = err_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        proto_err_d   = proto_err_q;
        done_valid_d  = retire;
        done_id_d     = done_id_q;
        done_err_d    = done_err_q;

        if (b_fire) begin
            rem_d[rd_ptr_q] = head_rem - BurstCntWidth'(1);
            err_d[rd_ptr_q] = err_q[rd_ptr_q] | resp_err;
        end

        // A full queue blocks accept, so the write slot never aliases the live head.
        if (accept) begin
            id_d[wr_ptr_q]  = insn_id_i;
            rem_d[wr_ptr_q] = insn_nbursts_i;
            err_d[wr_ptr_q] = 1'b0;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end

        if (retire) begin
            rd_ptr_d   = rd_ptr_q + PtrW'(1);
            done_id_d  = id_q[rd_ptr_q];
            done_err_d = err_q[rd_ptr_q] | (b_fire & resp_err);
        end

        case ({accept, retire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (aw_fire_i && !aw_credit_o) begin
            proto_err_d = 1'b1;
        end
        case ({aw_fire_i, b_fire})
            2'b10: begin
                if (aw_credit_o) begin
                    outstanding_d = outstanding_q + OutW'(1);
                end
            end
            2'b01: begin
                if (outstanding_q == '0) begin
                    proto_err_d = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - OutW'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QueueDepth; i++) begin
                id_q[i]  <= '0;
                rem_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            proto_err_q   <= 1'b0;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_err_q    <= 1'b0;
        end else begin
            id_q          <= id_d;
            rem_q         <= rem_d;
            err_q         <= err_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            proto_err_q   <= proto_err_d;
            done_valid_q  <= done_valid_d;
            done_id_q     <= done_id_d;
            done_err_q    <= done_err_d;
        end
    end

endmodule
